// File: rtl/led_pwm_driver_if.sv
// rtl/led_pwm_driver_if.sv - peripheral register bus shared with the LED bit peripheral
interface led_pwm_driver_if;
    logic [3:0]  address;
    logic        write_en;
    logic        read_en;
    logic [31:0] data_in;
    logic [31:0] data_out;

    modport master (
        output address,
        output write_en,
        output read_en,
        output data_in,
        input  data_out
    );

    modport slave (
        input  address,
        input  write_en,
        input  read_en,
        input  data_in,
        output data_out
    );
endinterface

// File: rtl/led_pwm_driver.sv
// rtl/led_pwm_driver.sv - LED pin driver with PWM brightness, blinking and polarity inversion
module led_pwm_driver #(
    parameter int PRESC_W = 16,
    parameter int BLINK_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    led_pwm_driver_if.slave   bus,
    input  logic              led_req,
    output logic              led_pin
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t               state, state_nxt;
    logic [2:0]           ctrl_r;
    logic [7:0]           duty_r;
    logic [PRESC_W-1:0]   presc_r;
    logic [BLINK_W-1:0]   blink_r;
    logic [PRESC_W-1:0]   presc_cnt;
    logic [7:0]           pwm_cnt;
    logic [BLINK_W-1:0]   blink_cnt;
    logic                 phase;

    logic enable, blink_en, invert;
    logic running, tick, period_end, pwm_on, raw;

    assign enable   = ctrl_r[0];
    assign blink_en = ctrl_r[1];
    assign invert   = ctrl_r[2];
    assign running  = (state == RUN);

    // >= rather than == so shrinking PRESC below the live count ticks at once
    assign tick       = running && (presc_cnt >= presc_r);
    assign period_end = tick && (pwm_cnt == 8'hFF);
    assign pwm_on     = (duty_r == 8'hFF) ? 1'b1 : (pwm_cnt < duty_r);
    assign raw        = running && pwm_on && (!blink_en || phase);

    // Configuration registers; upper data bits are simply dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_r  <= 3'b001;
            duty_r  <= 8'hFF;
            presc_r <= '0;
            blink_r <= '0;
        end else if (bus.write_en) begin
            case (bus.address)
                4'h1: ctrl_r  <= bus.data_in[2:0];
                4'h2: duty_r  <= bus.data_in[7:0];
                4'h3: presc_r <= bus.data_in[PRESC_W-1:0];
                4'h4: blink_r <= bus.data_in[BLINK_W-1:0];
                default: ;
            endcase
        end
    end

    // Combinational read mux; reflects pre-write contents on a same-cycle write
    always_comb begin
        bus.data_out = 32'h0;
        if (bus.read_en) begin
            case (bus.address)
                4'h1: bus.data_out = 32'(ctrl_r);
                4'h2: bus.data_out = 32'(duty_r);
                4'h3: bus.data_out = 32'(presc_r);
                4'h4: bus.data_out = 32'(blink_r);
                // phase is only meaningful while running, so it reads 0 when idle
                4'h5: bus.data_out = {29'h0, running, phase & running, led_pin};
                default: bus.data_out = 32'h0;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state: run only while enabled and requested
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (enable && led_req)    state_nxt = RUN;
            RUN:  if (!enable || !led_req)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Prescaler, PWM and blink counters; idle holds them so each run starts fresh and lit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_cnt <= '0;
            pwm_cnt   <= '0;
            blink_cnt <= '0;
            phase     <= 1'b1;
        end else if (!running) begin
            presc_cnt <= '0;
            pwm_cnt   <= '0;
            blink_cnt <= '0;
            phase     <= 1'b1;
        end else begin
            presc_cnt <= tick ? '0 : presc_cnt + 1'b1;
            if (tick)
                pwm_cnt <= pwm_cnt + 8'd1;
            if (period_end) begin
                if (blink_cnt >= blink_r) begin
                    phase     <= ~phase;
                    blink_cnt <= '0;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end
        end
    end

    // Registered pin drive with polarity inversion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) led_pin <= 1'b0;
        else        led_pin <= raw ^ invert;
    end
endmodule

// File: doc/led_pwm_driver.md
Name: led_pwm_driver

Overview:
- Downstream stage of the LED bit peripheral. It consumes that block's `led` output as `led_req` and drives the physical FPGA LED pin.
- Adds programmable PWM brightness, optional blinking and pin polarity inversion.
- Configured through the same peripheral bus as its neighbour, at word addresses 4'h1–4'h5. Address 4'h0 stays with the LED bit peripheral.
- Instantiated beside that peripheral in peripherals_min; `led_pin` is routed to top.

Parameters:
- PRESC_W, 16, width of the prescaler register and counter.
- BLINK_W, 16, width of the blink half-period register and counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- address  in  4  peripheral register address
- write_en  in  1  bus write strobe, single cycle
- read_en  in  1  bus read strobe
- data_in  in  32  write data
- data_out  out  32  read data, combinational
- led_req  in  1  LED request from the LED bit peripheral (1 = lit)
- led_pin  out  1  registered drive to the FPGA LED pin

Behaviour:
- Register map (all reset values apply on rst_n low):
  - 4'h1 CTRL[2:0]: bit0 enable, bit1 blink_en, bit2 invert. Reset 3'b001.
  - 4'h2 DUTY[7:0]: reset 8'hFF.
  - 4'h3 PRESC[PRESC_W-1:0]: reset 0.
  - 4'h4 BLINK[BLINK_W-1:0]: reset 0.
  - 4'h5 STATUS, read-only: bit0 led_pin, bit1 blink phase, bit2 state==RUN.
- Writes:
  - Write when write_en=1 and address matches; upper data_in bits are ignored.
  - Writes to STATUS, 4'h0 or 4'h6–4'hF are ignored.
- Reads:
  - data_out = zero-extended register when read_en=1 and address is 1–5; 32'h0 otherwise, including unread cycles.
  - A read and write in the same cycle return the pre-write value.
- FSM with two states, reset IDLE:
  - IDLE→RUN when enable && led_req.
  - RUN→IDLE when !enable || !led_req.
  - In IDLE, presc_cnt, pwm_cnt and blink_cnt are held at 0 and phase is held at 1, so every RUN entry starts a fresh period in the on-phase.
- Prescaler (RUN only):
  - tick = (presc_cnt >= PRESC).
  - On tick, presc_cnt←0; otherwise presc_cnt+1.
  - Using >= means a PRESC write below the current count produces a tick on the next cycle, never a wrap through 2^PRESC_W.
- PWM counter:
  - pwm_cnt is 8-bit and increments on tick, wrapping 255→0.
  - period_end = tick && pwm_cnt==255.
  - pwm_on = (DUTY==8'hFF) ? 1 : (pwm_cnt < DUTY).
  - DUTY=0 gives always off; DUTY=255 gives always on.
  - A duty write takes effect on the next comparison.
- Blink:
  - On period_end, if blink_cnt >= BLINK then phase toggles and blink_cnt←0; otherwise blink_cnt+1.
  - Each half-phase therefore lasts BLINK+1 PWM periods.
  - Clearing blink_en forces the phase gate open but does not reset phase or blink_cnt.
- Output:
  - raw = (state==RUN) && pwm_on && (!blink_en || phase).
  - led_pin ← raw ^ invert, registered.
  - Latency: led_req rising with enable=1 enters RUN on the next edge; led_pin first reflects RUN one edge after that (2 cycles).
  - Dropping led_req clears led_pin 2 cycles later.
- Reset:
  - led_pin=0, state=IDLE, all counters 0, phase=1.
  - A reset mid-operation aborts immediately and asynchronously.
  - After reset the block behaves as a plain pass-through of led_req, with the same 2-cycle latency.

Test Plan:
- Reset pass-through:
  - Stimulus: release reset, led_req=1.
  - Required: led_pin=1 from the 2nd cycle after; STATUS=0x7.
  - Then led_req=0 → led_pin=0 two cycles later; STATUS reads 0x0.
- PWM 50%:
  - Stimulus: DUTY=0x80, PRESC=0, led_req=1.
  - Required: led_pin high 128 clk, low 128 clk, period 256 clk, repeating.
  - DUTY=0 → pin constantly 0; DUTY=0xFF → constantly 1.
- Prescaler:
  - Stimulus: PRESC=3, DUTY=0x40.
  - Required: period 1024 clk with 256 clk high.
  - Rewriting PRESC=0 mid-count gives a tick on the next cycle and no long stall.
- Blink:
  - Stimulus: PRESC=0, DUTY=0xFF, BLINK=1, blink_en=1.
  - Required: led_pin high 512 clk, low 512 clk; STATUS bit1 toggles every 512 clk.
- Invert and disable:
  - invert=1 with led_req=0 → led_pin=1.
  - enable=0 with led_req=1 → pin equals invert, counters held at 0.
  - Re-enabling restarts in the on-phase with pwm_cnt=0.
- Bus edges:
  - Write 0xFFFFFFFF to DUTY → reads 0x000000FF.
  - A write to 4'h5 leaves STATUS unchanged.
  - A read of 4'h7 returns 0.
  - A read without read_en returns 0.
  - A simultaneous read/write of DUTY returns the old value.
  - Asserting rst_n low mid-blink immediately restores the reset values.
